status_word_reader: RTL and testbench

Read-back side of the processor status register. Packs the individual status fields (the same layout a 32-bit write-data word is sliced into on write) back into one 32-bit word and returns it through a request/response handshake. Also reports whether the status has changed since the previous read, and counts completed reads. Sits between the status register block and the CSR read mux.

---
 rtl/status_word_reader.sv | 77 +++++++
 tb/tb_status_word_reader.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/status_word_reader.sv
// Packs the status fields into one 32-bit word, captures it on request and returns it 1 cycle later.
// Holds the response until it is taken; a request and a taken response in the same cycle give one read per cycle.
module status_word_reader (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_status_et,
    input  logic        io_status_ef,
    input  logic        io_status_ev,
    input  logic        io_status_ec,
    input  logic        io_status_ps,
    input  logic        io_status_s,
    input  logic        io_status_u64,
    input  logic        io_status_s64,
    input  logic        io_status_vm,
    input  logic [6:0]  io_status_zero,
    input  logic [7:0]  io_status_im,
    input  logic        io_req_valid,
    output logic        io_req_ready,
    output logic        io_resp_valid,
    input  logic        io_resp_ready,
    output logic [31:0] io_resp_bits_data,
    output logic        io_resp_bits_changed,
    output logic [7:0]  io_read_count
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    state_t      r_state;
    logic [31:0] r_data;
    logic [31:0] r_snap;
    logic        r_changed;
    logic [7:0]  r_count;

    logic [31:0] w_packed;
    logic        w_hs;
    logic        w_accept;

    assign w_packed = {8'h00, io_status_im, io_status_zero, io_status_vm, io_status_s64,
                       io_status_u64, io_status_s, io_status_ps, io_status_ec,
                       io_status_ev, io_status_ef, io_status_et};

    assign io_resp_valid        = (r_state == ST_RESP);
    assign w_hs                 = io_resp_valid & io_resp_ready;
    // Ready may look through a response being taken this cycle, so reads stream back-to-back.
    assign io_req_ready         = (r_state == ST_IDLE) | w_hs;
    assign w_accept             = io_req_valid & io_req_ready;

    assign io_resp_bits_data    = r_data;
    assign io_resp_bits_changed = r_changed;
    assign io_read_count        = r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_data    <= 32'h0;
            r_snap    <= 32'h0;
            r_changed <= 1'b0;
            r_count   <= 8'h00;
        end else begin
            if (w_accept) begin
                r_data    <= w_packed;
                r_changed <= (w_packed != r_snap);
                r_snap    <= w_packed;
                r_state   <= ST_RESP;
            end else if (w_hs) begin
                r_state   <= ST_IDLE;
            end
            if (w_hs) begin
                r_count <= r_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_status_word_reader.sv
// Directed bench for status_word_reader with hand-computed expected words and a tracked read count.
module tb_status_word_reader;

    logic        clk;
    logic        reset;
    logic        io_status_et, io_status_ef, io_status_ev, io_status_ec, io_status_ps;
    logic        io_status_s, io_status_u64, io_status_s64, io_status_vm;
    logic [6:0]  io_status_zero;
    logic [7:0]  io_status_im;
    logic        io_req_valid;
    logic        io_req_ready;
    logic        io_resp_valid;
    logic        io_resp_ready;
    logic [31:0] io_resp_bits_data;
    logic        io_resp_bits_changed;
    logic [7:0]  io_read_count;

    int          n_cmp;
    int          n_err;
    logic [7:0]  exp_cnt;

    status_word_reader dut (
        .clk                  (clk),
        .reset                (reset),
        .io_status_et         (io_status_et),
        .io_status_ef         (io_status_ef),
        .io_status_ev         (io_status_ev),
        .io_status_ec         (io_status_ec),
        .io_status_ps         (io_status_ps),
        .io_status_s          (io_status_s),
        .io_status_u64        (io_status_u64),
        .io_status_s64        (io_status_s64),
        .io_status_vm         (io_status_vm),
        .io_status_zero       (io_status_zero),
        .io_status_im         (io_status_im),
        .io_req_valid         (io_req_valid),
        .io_req_ready         (io_req_ready),
        .io_resp_valid        (io_resp_valid),
        .io_resp_ready        (io_resp_ready),
        .io_resp_bits_data    (io_resp_bits_data),
        .io_resp_bits_changed (io_resp_bits_changed),
        .io_read_count        (io_read_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_status(input logic [31:0] w);
        io_status_et   = w[0];
        io_status_ef   = w[1];
        io_status_ev   = w[2];
        io_status_ec   = w[3];
        io_status_ps   = w[4];
        io_status_s    = w[5];
        io_status_u64  = w[6];
        io_status_s64  = w[7];
        io_status_vm   = w[8];
        io_status_zero = w[15:9];
        io_status_im   = w[23:16];
    endtask

    // One request pulse, check the captured word, then take the response.
    task automatic read_word(input string tag, input logic [31:0] w, input logic exp_chg);
        set_status(w);
        io_req_valid = 1'b1;
        step();
        io_req_valid = 1'b0;
        check_eq({tag, "_valid"}, {31'h0, io_resp_valid}, 32'h1);
        check_eq({tag, "_data"}, io_resp_bits_data, {8'h00, w[23:0]});
        check_eq({tag, "_changed"}, {31'h0, io_resp_bits_changed}, {31'h0, exp_chg});
        io_resp_ready = 1'b1;
        step();
        io_resp_ready = 1'b0;
        exp_cnt = exp_cnt + 8'd1;
        check_eq({tag, "_count"}, {24'h0, io_read_count}, {24'h0, exp_cnt});
        check_eq({tag, "_idle"}, {31'h0, io_resp_valid}, 32'h0);
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        exp_cnt       = 8'h00;
        reset         = 1'b1;
        io_req_valid  = 1'b0;
        io_resp_ready = 1'b0;
        set_status(32'h0);

        // Reset defaults
        step();
        step();
        reset = 1'b0;
        check_eq("rst_valid", {31'h0, io_resp_valid}, 32'h0);
        check_eq("rst_data", io_resp_bits_data, 32'h0);
        check_eq("rst_changed", {31'h0, io_resp_bits_changed}, 32'h0);
        check_eq("rst_count", {24'h0, io_read_count}, 32'h0);
        check_eq("rst_ready", {31'h0, io_req_ready}, 32'h1);

        // Basic read: im=A5, vm=1, et=1
        set_status(32'h00A5_0101);
        io_req_valid = 1'b1;
        step();
        io_req_valid = 1'b0;
        check_eq("basic_valid", {31'h0, io_resp_valid}, 32'h1);
        check_eq("basic_data", io_resp_bits_data, 32'h00A5_0101);
        check_eq("basic_changed", {31'h0, io_resp_bits_changed}, 32'h1);
        check_eq("basic_ready_stalled", {31'h0, io_req_ready}, 32'h0);
        io_resp_ready = 1'b1;
        #1;
        check_eq("basic_ready_passthru", {31'h0, io_req_ready}, 32'h1);
        step();
        io_resp_ready = 1'b0;
        exp_cnt = 8'd1;
        check_eq("basic_count", {24'h0, io_read_count}, 32'h1);
        check_eq("basic_idle", {31'h0, io_resp_valid}, 32'h0);

        // Stall: response holds while inputs toggle
        set_status(32'h0000_0003);
        io_req_valid = 1'b1;
        step();
        io_req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_status(i[0] ? 32'h00FF_FFFC : 32'h005A_A5A0);
            io_req_valid = i[0];
            step();
            check_eq("stall_data", io_resp_bits_data, 32'h0000_0003);
            check_eq("stall_ready", {31'h0, io_req_ready}, 32'h0);
            check_eq("stall_valid", {31'h0, io_resp_valid}, 32'h1);
            check_eq("stall_changed", {31'h0, io_resp_bits_changed}, 32'h1);
        end
        io_req_valid  = 1'b0;
        io_resp_ready = 1'b1;
        step();
        io_resp_ready = 1'b0;
        exp_cnt = 8'd2;
        check_eq("stall_count", {24'h0, io_read_count}, 32'h2);

        // Change detect: same word twice, then flip ps only
        read_word("chg_first", 32'h0012_0034, 1'b1);
        read_word("chg_same", 32'h0012_0034, 1'b0);
        read_word("chg_ps", 32'h0012_0024, 1'b1);

        // Back-to-back with et toggling each cycle
        io_req_valid  = 1'b1;
        io_resp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set_status(32'h0012_0024 | {31'h0, ~i[0]});
            step();
            check_eq("b2b_valid", {31'h0, io_resp_valid}, 32'h1);
            check_eq("b2b_data", io_resp_bits_data, 32'h0012_0024 | {31'h0, ~i[0]});
            check_eq("b2b_changed", {31'h0, io_resp_bits_changed}, 32'h1);
        end
        io_req_valid = 1'b0;
        step();
        io_resp_ready = 1'b0;
        exp_cnt = exp_cnt + 8'd10;
        check_eq("b2b_count", {24'h0, io_read_count}, {24'h0, exp_cnt});
        check_eq("b2b_idle", {31'h0, io_resp_valid}, 32'h0);

        // Reset while a response is pending
        set_status(32'h00C3_0011);
        io_req_valid = 1'b1;
        step();
        io_req_valid = 1'b0;
        check_eq("mid_valid_before", {31'h0, io_resp_valid}, 32'h1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_cnt = 8'h00;
        check_eq("mid_valid", {31'h0, io_resp_valid}, 32'h0);
        check_eq("mid_count", {24'h0, io_read_count}, 32'h0);
        check_eq("mid_data", io_resp_bits_data, 32'h0);
        check_eq("mid_ready", {31'h0, io_req_ready}, 32'h1);

        // First read after reset of an all-zero word reports no change
        read_word("zero_first", 32'h0, 1'b0);

        // Wrap: 255 more reads streamed, count passes 255 then wraps to 0
        set_status(32'h0000_0001);
        io_req_valid  = 1'b1;
        io_resp_ready = 1'b1;
        for (int i = 0; i < 255; i++) begin
            step();
        end
        io_req_valid = 1'b0;
        check_eq("wrap_count_255", {24'h0, io_read_count}, 32'hFF);
        step();
        io_resp_ready = 1'b0;
        check_eq("wrap_count_0", {24'h0, io_read_count}, 32'h0);
        check_eq("wrap_idle", {31'h0, io_resp_valid}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
